dmem_wait_responder: RTL and testbench

- Data-memory responder for the pipelined core's data port, holding words of RAM behind a request/ready handshake with a configurable number of wait states.
- Sits where the single-cycle data memory sits today; its stall output feeds the hazard unit so the pipeline holds while an access is outstanding.
- Flags misaligned and out-of-range accesses with an error response instead of silently aliasing them.

---
 rtl/dmem_wait_responder_if.sv | 21 ++
 rtl/dmem_wait_responder.sv | 93 +++++++++
 tb/tb_dmem_wait_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_wait_responder_if.sv
// Data-port handshake between the memory stage (master) and the data-memory responder (slave).
interface dmem_wait_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        stall_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, rdata_o, err_o, stall_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, rdata_o, err_o, stall_o
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data RAM with a programmable wait-state count; misaligned and
// out-of-range accesses complete with an error response instead of aliasing.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_wait_responder_if.slave bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} stateT;

  stateT          state;
  logic [3:0]     cnt;
  logic [AW-1:0]  addrQ;
  logic           weQ;
  logic [31:0]    wdataQ;
  logic           readyQ;
  logic           errQ;
  logic [31:0]    rdataQ;
  logic [31:0]    mem [DEPTH_WORDS];
  logic           badAddr;

  assign badAddr = (bus.addr_i[1:0] != 2'b00) ||
                   ({2'b00, bus.addr_i[31:2]} >= 32'(DEPTH_WORDS));

  assign bus.ready_o = readyQ;
  assign bus.err_o   = errQ;
  assign bus.rdata_o = rdataQ;
  assign bus.stall_o = ((state == IDLE) && bus.req_i) || (state == WAIT);

  // Outputs are registered on entry to RESP/ERR, so they are computed on the
  // transition edge rather than decoded from the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addrQ  <= '0;
      weQ    <= 1'b0;
      wdataQ <= '0;
      readyQ <= 1'b0;
      errQ   <= 1'b0;
      rdataQ <= '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH_WORDS); i++) begin
        mem[AW'(i)] <= '0;
      end
    end else begin
      readyQ <= 1'b0;
      errQ   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            addrQ  <= bus.addr_i[AW+1:2];
            weQ    <= bus.we_i;
            wdataQ <= bus.wdata_i;
            if (badAddr) begin
              state  <= ERR;
              readyQ <= 1'b1;
              errQ   <= 1'b1;
              rdataQ <= '0;
            end else if (WAIT_CYCLES == 0) begin
              state  <= RESP;
              readyQ <= 1'b1;
              if (!bus.we_i) rdataQ <= mem[bus.addr_i[AW+1:2]];
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state  <= RESP;
            readyQ <= 1'b1;
            if (!weQ) rdataQ <= mem[addrQ];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (weQ) mem[addrQ] <= wdataQ;
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomised and directed bench for dmem_wait_responder across several wait-state
// settings, checked against a transaction-level memory model.
module tb_dmem_wait_responder;
  localparam int NDUT  = 4;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rstA   [NDUT];
  logic        reqA   [NDUT];
  logic        weA    [NDUT];
  logic [31:0] addrA  [NDUT];
  logic [31:0] wdataA [NDUT];
  logic        readyA [NDUT];
  logic        errA   [NDUT];
  logic        stallA [NDUT];
  logic [31:0] rdataA [NDUT];

  int checks = 0;
  int errors = 0;

  logic [31:0] refMem [NDUT][DEPTH];
  logic [31:0] lastR  [NDUT];

  function automatic int wcOf(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int W = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
    dmem_wait_responder_if bus ();
    assign bus.req_i   = reqA[g];
    assign bus.we_i    = weA[g];
    assign bus.addr_i  = addrA[g];
    assign bus.wdata_i = wdataA[g];
    assign readyA[g]   = bus.ready_o;
    assign errA[g]     = bus.err_o;
    assign stallA[g]   = bus.stall_o;
    assign rdataA[g]   = bus.rdata_o;

    dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk   (clk),
      .reset (rstA[g]),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset(input int d);
    for (int i = 0; i < DEPTH; i++) refMem[d][i] = '0;
    lastR[d] = '0;
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic doReset(input int d);
    rstA[d] = 1'b1;
    reqA[d] = 1'b0;
    #1;
    modelReset(d);
    checkVal("rstReady", 32'(readyA[d]), 32'd0);
    checkVal("rstErr",   32'(errA[d]),   32'd0);
    checkVal("rstRdata", rdataA[d],      32'd0);
    checkVal("rstStall", 32'(stallA[d]), 32'd0);
    @(negedge clk);
    rstA[d] = 1'b0;
  endtask

  // Full access from the request cycle through the idle cycle that follows the response.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input bit dropEarly);
    int        wc;
    bit        legal;
    int        respAt;
    int        idx;
    logic [31:0] expR;
    wc     = wcOf(d);
    legal  = (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DEPTH));
    respAt = legal ? wc : 0;
    idx    = int'(a[7:2]);
    reqA[d] = 1'b1; weA[d] = w; addrA[d] = a; wdataA[d] = wd;
    #1;
    checkVal("reqStall", 32'(stallA[d]), 32'd1);
    checkVal("reqReady", 32'(readyA[d]), 32'd0);
    for (int k = 0; k <= respAt; k++) begin
      @(negedge clk);
      if (k < respAt) begin
        checkVal("waitReady", 32'(readyA[d]), 32'd0);
        checkVal("waitStall", 32'(stallA[d]), 32'd1);
        if (dropEarly) begin
          reqA[d] = 1'b0;
          addrA[d] = $urandom; wdataA[d] = $urandom; weA[d] = ~w;
        end
      end
    end
    if (!legal)  expR = '0;
    else if (w)  expR = lastR[d];
    else         expR = refMem[d][idx];
    checkVal("respReady", 32'(readyA[d]), 32'd1);
    checkVal("respErr",   32'(errA[d]),   legal ? 32'd0 : 32'd1);
    checkVal("respRdata", rdataA[d],      expR);
    checkVal("respStall", 32'(stallA[d]), 32'd0);
    lastR[d] = expR;
    if (legal && w) refMem[d][idx] = wd;
    reqA[d] = 1'b0;
    @(negedge clk);
    checkVal("idleReady", 32'(readyA[d]), 32'd0);
    checkVal("holdRdata", rdataA[d],      lastR[d]);
    checkVal("idleStall", 32'(stallA[d]), 32'd0);
  endtask

  task automatic randomRun(input int d, input int n);
    logic [31:0] a;
    int          pick;
    for (int i = 0; i < n; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 6)      a = {24'd0, 6'($urandom_range(0, 7)), 2'b00};
      else if (pick < 8) a = {24'd0, 6'($urandom), 2'b00};
      else if (pick < 9) a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
      else               a = 32'h100 + {$urandom_range(0, 1000), 2'b00};
      access(d, 1'($urandom), a, $urandom, 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rstA[d] = 1'b1; reqA[d] = 1'b0; weA[d] = 1'b0;
      addrA[d] = '0; wdataA[d] = '0;
      modelReset(d);
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) doReset(d);

    // Two wait states: fresh read, write/readback, error cases.
    access(0, 1'b0, 32'h8,  32'h0,        1'b0);
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0,        1'b0);
    access(0, 1'b1, 32'h0,  32'h12345678, 1'b0);
    access(0, 1'b1, 32'h6,  32'hFFFFFFFF, 1'b0);
    access(0, 1'b0, 32'h0,  32'h0,        1'b0);
    access(0, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b0);
    access(0, 1'b0, 32'h0,  32'h0,        1'b0);
    access(0, 1'b1, 32'h14, 32'hCAFEF00D, 1'b1);
    access(0, 1'b0, 32'h14, 32'h0,        1'b0);

    // Zero wait states, back-to-back.
    access(1, 1'b1, 32'h0, 32'h1, 1'b0);
    access(1, 1'b0, 32'h0, 32'h0, 1'b0);
    access(1, 1'b0, 32'h3, 32'h0, 1'b0);
    access(1, 1'b0, 32'hFC, 32'h0, 1'b0);

    // Three wait states: asynchronous reset in the middle of a write.
    access(2, 1'b1, 32'h8, 32'h77, 1'b0);
    access(2, 1'b0, 32'h8, 32'h0,  1'b0);
    reqA[2] = 1'b1; weA[2] = 1'b1; addrA[2] = 32'h4; wdataA[2] = 32'h55;
    @(negedge clk);
    checkVal("midWaitStall", 32'(stallA[2]), 32'd1);
    #2;
    rstA[2] = 1'b1;
    reqA[2] = 1'b0;
    #1;
    modelReset(2);
    checkVal("asyncRdata", rdataA[2],      32'd0);
    checkVal("asyncReady", 32'(readyA[2]), 32'd0);
    checkVal("asyncStall", 32'(stallA[2]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstA[2] = 1'b0;
    access(2, 1'b0, 32'h4, 32'h0, 1'b0);
    access(2, 1'b0, 32'h8, 32'h0, 1'b0);

    // Fifteen wait states: last word.
    access(3, 1'b1, 32'hFC, 32'hA5A5A5A5, 1'b0);
    access(3, 1'b0, 32'hFC, 32'h0,        1'b0);
    access(3, 1'b0, 32'h100, 32'h0,       1'b0);

    for (int d = 0; d < NDUT; d++) randomRun(d, (d == 3) ? 20 : 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
